// File: rtl/mult_arbiter_pkg.sv
// mult_arbiter_pkg: shared states, defaults and sizing helper
// for the multiplier-sharing arbiter.
package mult_arbiter_pkg;

  localparam int DEF_N       = 4;
  localparam int DEF_WIDTH   = 16;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_arbiter_rr_picker.sv
// rr_picker: combinational round-robin picker, first set request
// searching upward from ptr+1 modulo N.
module rr_picker
  import mult_arbiter_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one start/ready signed multiplier core
// among N requesters, round-robin, with a response timeout.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            req_valid,
  output logic [N-1:0]            req_ready,
  input  logic [N*WIDTH-1:0]      req_a,
  input  logic [N*WIDTH-1:0]      req_b,
  output logic [N-1:0]            resp_valid,
  input  logic [N-1:0]            resp_ready,
  output logic [2*WIDTH-1:0]      resp_product,
  output logic                    resp_err,
  output logic [WIDTH-1:0]        mul_a,
  output logic [WIDTH-1:0]        mul_b,
  output logic                    mul_start,
  input  logic                    mul_ready,
  input  logic [2*WIDTH-1:0]      mul_product,
  output logic                    busy,
  output logic [idx_w(N)-1:0]     grant_id
);

  localparam int IW = idx_w(N);
  localparam int CW = idx_w(TIMEOUT);

  state_e               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        gid_q, gid_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 err_q, err_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [N-1:0]         pick_oh;
  logic [IW-1:0]        pick_idx;
  logic [WIDTH-1:0]     sel_a, sel_b;
  logic                 idle;

  rr_picker #(
    .N  (N),
    .IW (IW)
  ) u_picker (
    .req    (req_valid),
    .ptr    (ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_oh[i]) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign idle         = (state_q == ST_IDLE);
  assign req_ready    = (idle && !rst) ? pick_oh : '0;
  assign mul_start    = (state_q == ST_ISSUE);
  assign mul_a        = a_q;
  assign mul_b        = b_q;
  assign busy         = !idle;
  assign grant_id     = gid_q;
  assign resp_product = prod_q;
  assign resp_err     = err_q;

  always_comb begin
    resp_valid = '0;
    if (state_q == ST_RESP) resp_valid[gid_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|pick_oh) begin
          a_d     = sel_a;
          b_d     = sel_b;
          gid_d   = pick_idx;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // first WAIT cycle may still see ready from the previous op
        if ((cnt_q != '0) && mul_ready) begin
          prod_d  = mul_product;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready[gid_q]) begin
          ptr_d   = gid_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= IW'(N - 1);
      gid_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed vector bench with a behavioural
// start/ready multiplier core model.
module tb_mult_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 64;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic [N-1:0]     resp_valid;
  logic [N-1:0]     resp_ready = '0;
  logic [2*W-1:0]   resp_product;
  logic             resp_err;
  logic [W-1:0]     mul_a, mul_b;
  logic             mul_start;
  logic             mul_ready;
  logic [2*W-1:0]   mul_product;
  logic             busy;
  logic [IW-1:0]    grant_id;

  int checks = 0;
  int errors = 0;

  int c_lat   = 3;
  bit c_dead  = 1'b0;
  bit c_stale = 1'b0;

  always #5 clk = ~clk;

  mult_arbiter #(
    .N       (N),
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_product (resp_product),
    .resp_err     (resp_err),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_start    (mul_start),
    .mul_ready    (mul_ready),
    .mul_product  (mul_product),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  // core model: ready rises c_lat edges after the start edge and
  // stays high until the next start (or later, in stale mode)
  logic signed [2*W-1:0] core_p;
  int since;
  bit active;

  always @(posedge clk) begin
    if (rst) begin
      mul_ready   <= 1'b0;
      mul_product <= '0;
      core_p      <= '0;
      active      <= 1'b0;
      since       <= 0;
    end else if (mul_start) begin
      core_p <= $signed(mul_a) * $signed(mul_b);
      since  <= 1;
      active <= 1'b1;
      if (!c_stale) mul_ready <= 1'b0;
    end else if (active) begin
      since <= since + 1;
      if (c_stale && since == 1) mul_ready <= 1'b0;
      if (!c_dead && since == c_lat) begin
        mul_ready   <= 1'b1;
        mul_product <= core_p;
        active      <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input longint got,
                     input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic serve(input int eg, input longint ea,
                       input longint eb, input longint ep,
                       input bit ee, input int elat,
                       input int hold, input logic [N-1:0] nextv,
                       input bit scr);
    int n;
    int starts;
    int t;
    logic [N-1:0] m;
    m = N'(1) << eg;
    t = 0;
    #1;
    while (req_ready == '0 && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("req_ready", req_ready, m);
    chk("busy_idle", busy, 0);
    @(negedge clk);
    req_valid = nextv;
    if (scr) begin
      req_a = ~req_a;
      req_b = ~req_b;
    end
    #1;
    chk("mul_start", mul_start, 1);
    chk("grant_id", grant_id, eg);
    chk("mul_a", $signed(mul_a), ea);
    chk("mul_b", $signed(mul_b), eb);
    n = 0;
    starts = 1;
    while (resp_valid == '0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
      if (mul_start) starts++;
    end
    chk("start_width", starts, 1);
    chk("latency", n, elat);
    chk("resp_valid", resp_valid, m);
    chk("resp_product", $signed(resp_product), ep);
    chk("resp_err", resp_err, ee);
    for (int h = 0; h < hold; h++) begin
      resp_ready = ~m;
      @(negedge clk);
      #1;
      chk("bp_valid", resp_valid, m);
      chk("bp_product", $signed(resp_product), ep);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
    end
    resp_ready = m;
    @(negedge clk);
    resp_ready = '0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_resp_valid", resp_valid, 0);
  endtask

  typedef struct {
    int     r;
    longint a;
    longint b;
    int     lat;
    bit     dead;
    bit     stale;
    longint ep;
    bit     ee;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, -1, 1, 17, 1'b0, 1'b0, -1, 1'b0};
    tbl[1] = '{2, 7, -3, 2, 1'b0, 1'b0, -21, 1'b0};
    tbl[2] = '{3, -32768, -32768, 5, 1'b0, 1'b0, 1073741824, 1'b0};
    tbl[3] = '{1, 32767, -32768, 3, 1'b0, 1'b0, -1073709056, 1'b0};
    tbl[4] = '{1, 5, 5, 4, 1'b1, 1'b0, 0, 1'b1};
    tbl[5] = '{0, 12, 12, 4, 1'b0, 1'b0, 144, 1'b0};
    tbl[6] = '{2, 12345, -1, 6, 1'b0, 1'b1, -12345, 1'b0};

    // reset with every requester already valid
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'(i + 1);
      req_b[i*W +: W] = W'(-100);
    end
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_product", resp_product, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_mul_a", mul_a, 0);
    rst = 1'b0;

    // round robin under continuous requests
    c_lat = 3;
    for (int g = 0; g < 5; g++) begin
      serve(g % N, (g % N) + 1, -100, -100 * ((g % N) + 1),
            1'b0, c_lat + 2, 0, (g == 4) ? '0 : '1, 1'b0);
    end

    // single-requester vectors incl. timeout and stale ready
    for (int i = 0; i < 7; i++) begin
      c_lat   = tbl[i].lat;
      c_dead  = tbl[i].dead;
      c_stale = tbl[i].stale;
      req_valid = N'(1) << tbl[i].r;
      req_a[tbl[i].r*W +: W] = tbl[i].a[W-1:0];
      req_b[tbl[i].r*W +: W] = tbl[i].b[W-1:0];
      serve(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].ep, tbl[i].ee,
            tbl[i].dead ? TO + 1 : tbl[i].lat + 2, 0, '0, 1'b1);
      c_stale = 1'b0;
      c_dead  = 1'b0;
    end

    // response backpressure on requester 2, requester 0 waiting
    c_lat = 2;
    req_valid = 4'b0100;
    req_a[2*W +: W] = W'(3);
    req_b[2*W +: W] = W'(5);
    req_a[0 +: W]   = W'(-2);
    req_b[0 +: W]   = W'(4);
    serve(2, 3, 5, 15, 1'b0, 4, 10, 4'b0001, 1'b0);
    serve(0, -2, 4, -8, 1'b0, 4, 0, '0, 1'b0);

    // reset in the middle of WAIT
    c_lat = 20;
    req_valid = 4'b0010;
    req_a[W +: W] = W'(9);
    req_b[W +: W] = W'(9);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("wait_busy", busy, 1);
    chk("wait_grant", grant_id, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_resp_valid", resp_valid, 0);
    chk("mrst_req_ready", req_ready, 0);
    chk("mrst_mul_start", mul_start, 0);
    chk("mrst_grant_id", grant_id, 0);
    chk("mrst_mul_a", mul_a, 0);
    chk("mrst_mul_b", mul_b, 0);
    chk("mrst_product", resp_product, 0);
    chk("mrst_err", resp_err, 0);
    c_lat = 3;
    req_valid = '1;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'(i + 2);
      req_b[i*W +: W] = W'(3);
    end
    rst = 1'b0;
    serve(0, 2, 3, 6, 1'b0, 5, 0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer that shares one sequential signed multiplier core (start/ready handshake, WIDTH×WIDTH → 2·WIDTH) among N requesters. It sits between the requester-side valid/ready channels and the core's operand/start/ready/product port. It grants one request at a time, pulses the core's start, and waits for ready with a timeout. It returns the signed product to the granted requester.

## Interface
- N, 4, number of requesters (2..8)
- WIDTH, 16, operand width; product is 2·WIDTH
- TIMEOUT, 64, max WAIT cycles before error (≥ 2)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N  per-requester request
- req_ready  out  N  one-hot accept; only in IDLE, only for picked requester
- req_a  in  N·WIDTH  signed multiplicand, requester i at [i·WIDTH +: WIDTH]
- req_b  in  N·WIDTH  signed multiplier, same packing
- resp_valid  out  N  one-hot response valid
- resp_ready  in  N  per-requester response accept
- resp_product  out  2·WIDTH  signed product (shared bus)
- resp_err  out  1  response is a timeout error
- mul_a, mul_b  out  WIDTH  operands to core, held stable ISSUE..WAIT
- mul_start  out  1  one-cycle start pulse
- mul_ready  in  1  core product valid
- mul_product  in  2·WIDTH  core product
- busy  out  1  state ≠ IDLE
- grant_id  out  clog2(N)  index of current/last grant

## Operation
- States: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE: the picker selects the first requester with req_valid set, searching from ptr+1 modulo N. req_ready[g]=1 combinationally. On the handshake, latch a, b and g, set grant_id=g, and go to ISSUE. With no valid requests, stay in IDLE.
- ISSUE: mul_start=1 for exactly one cycle. Go to WAIT and clear the wait counter.
- WAIT: the counter increments each cycle. mul_ready is ignored in the first WAIT cycle, because the core's ready from a prior op may still be high.
  - If count ≥ 1 and mul_ready: latch mul_product, set err=0, go to RESP.
  - Else if count = TIMEOUT−1: set product=0, err=1, go to RESP.
  - If ready and timeout occur in the same cycle, ready wins.
- RESP: resp_valid[g]=1, with resp_product and resp_err stable. On resp_ready[g], set ptr=g and go to IDLE. resp_ready on other bits is ignored.
- Arithmetic: no sign-extension or checking is done by the arbiter. The product is passed through unmodified.
- Non-granted requesters may change req_valid or operands freely. A granted requester's operands are captured, so later changes have no effect.

## Timing
- Reset values:
  - state=IDLE, ptr=N−1 (requester 0 has first priority)
  - req_ready=0 (combinational; follows valid after reset), resp_valid=0, resp_product=0, resp_err=0
  - mul_a=0, mul_b=0, mul_start=0, busy=0, grant_id=0, counter=0
- Reset mid-operation: abandon the transaction and discard any response. The parent resets the core in the same cycle.
- Latency:
  - Request accepted at edge k.
  - mul_start is high during cycle k+1.
  - Core ready seen at edge r.
  - resp_valid is high from cycle r+1.
  - Minimum turnaround back to IDLE is one cycle after resp_ready.
- Back-to-back: a new request cannot be accepted in the same cycle as a response handshake. IDLE lasts at least one cycle.
- Fairness: each requester waits at most N−1 grants while continuously valid.

## Structure
- Package mult_arbiter_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - function clog2-based IDX_W
  - default WIDTH, N and TIMEOUT constants
- Sub-module rr_picker: combinational round-robin one-hot picker with parameter N; inputs req and ptr; outputs onehot and idx.
- The core is not instantiated here. A wrapper connects the two blocks.

## Test plan
- Single requester: req 0 with a=−1, b=1, core ready after 17 cycles → resp_valid=0001, resp_product=−1, err=0. mul_start is exactly one cycle wide.
- All four requesters valid continuously from reset → grants in order 0,1,2,3,0. Operands a=i+1, b=−100 → products −100, −200, −300, −400.
- Stale ready: mul_ready held high through ISSUE and the first WAIT cycle, then the true product 12345·(−1) arrives → the response is −12345, and no early capture occurs.
- Timeout: mul_ready is never asserted → resp_err=1, product=0, after exactly TIMEOUT WAIT cycles. The next grant proceeds normally.
- Response backpressure: resp_ready[2] held low for 10 cycles → resp_valid and product stay stable, no new req_ready is asserted, and busy=1.
- rst asserted during WAIT → the next cycle shows state IDLE, all outputs at reset values, and requester 0 gets the next grant.
